// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: arbitrates two requesters onto one combinational ALU.
// A round-robin grant picks a requester in IDLE, its operands are registered
// toward the ALU, the ALU result is captured one cycle later and returned on
// a single response channel tagged with the issuing requester's ID.
module alu_rr_scheduler #(
  parameter int DW   = 8,
  parameter int SELW = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [SELW-1:0] req0_sel,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [SELW-1:0] req1_sel,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [SELW-1:0] alu_sel,
  input  logic [DW-1:0]   alu_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_id,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;  // requester accepted most recently; the other wins a tie
  logic   cur_id;      // requester owning the in-flight operation
  logic   grant;
  logic   accept;
  logic   rsp_done;

  // Next-state, round-robin grant and combinational ready generation
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant = ~last_grant;
        end else if (req1_valid) begin
          grant = 1'b1;
        end else begin
          grant = 1'b0;
        end
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
          if (grant) begin
            req1_ready = 1'b1;
          end else begin
            req0_ready = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rsp_done = (state == RESP) && rsp_valid && rsp_ready;
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand registers toward the ALU, plus grant bookkeeping; change only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= {DW{1'b0}};
      alu_b      <= {DW{1'b0}};
      alu_sel    <= {SELW{1'b0}};
      cur_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_a      <= grant ? req1_a   : req0_a;
      alu_b      <= grant ? req1_b   : req0_b;
      alu_sel    <= grant ? req1_sel : req0_sel;
      cur_id     <= grant;
      last_grant <= grant;
    end
  end

  // Response capture after the ALU settles, held until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= {DW{1'b0}};
      rsp_id    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
      rsp_id    <= cur_id;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= {CNTW{1'b0}};
    end else if (rsp_done) begin
      op_count <= op_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: scoreboard bench for the two-requester ALU scheduler.
// The counter is built narrow here so that its wrap can be reached quickly.
module tb_alu_rr_scheduler;

  localparam int CNTW = 4;

  logic            clk;
  logic            rst;
  logic            req0_valid;
  logic            req0_ready;
  logic [7:0]      req0_a;
  logic [7:0]      req0_b;
  logic [2:0]      req0_sel;
  logic            req1_valid;
  logic            req1_ready;
  logic [7:0]      req1_a;
  logic [7:0]      req1_b;
  logic [2:0]      req1_sel;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_sel;
  logic [7:0]      alu_y;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_data;
  logic            rsp_id;
  logic            busy;
  logic [CNTW-1:0] op_count;

  int         total;
  int         passed;
  int         cyc;
  int         exp_count;
  logic       model_last;
  logic [8:0] exp_q[$];

  alu_rr_scheduler #(.DW(8), .SELW(3), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Bench ALU: addition mod 256 for every opcode
  assign alu_y = alu_a + alu_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure issue intervals
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Issue one operation and follow it to its response (rsp_ready held 1).
  // Pushes the model's expected {id,data} at accept; returns observations only.
  task automatic drive_op(input logic v0, input logic v1,
                          input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1,
                          input logic hold,
                          output logic got_gid, output logic both_rdy,
                          output int acc_cyc, output int lat,
                          output logic [7:0] got_data, output logic got_id,
                          output logic done);
    logic       exp_gid;
    logic [7:0] exp_sum;
    done = 1'b0; got_gid = 1'b0; both_rdy = 1'b0; acc_cyc = 0; lat = 0;
    got_data = 8'd0; got_id = 1'b0;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = 3'd0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = 3'd5;
    rsp_ready  = 1'b1;
    #1;
    for (int i = 0; i < 8 && !(req0_ready || req1_ready); i++) begin
      @(negedge clk);
      #1;
    end
    if (!(req0_ready || req1_ready)) return;
    exp_gid    = (v0 && v1) ? ~model_last : v1;
    model_last = exp_gid;
    exp_sum    = exp_gid ? (a1 + b1) : (a0 + b0);
    exp_q.push_back({exp_gid, exp_sum});
    got_gid  = req1_ready;
    both_rdy = req0_ready && req1_ready;
    acc_cyc  = cyc;
    do begin
      @(negedge clk);
      if (!hold) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      lat++;
    end while (!rsp_valid && lat < 8);
    if (!rsp_valid) return;
    got_data  = rsp_data;
    got_id    = rsp_id;
    done      = 1'b1;
    exp_count = exp_count + 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    exp_count  = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_sel = 3'd0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_sel = 3'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, rsp_valid, rsp_id, rsp_data} !== 11'd0) begin
      $display("FAIL reset_rsp: busy=%0d rsp_valid=%0d rsp_id=%0d rsp_data=%0h, want all 0",
               busy, rsp_valid, rsp_id, rsp_data);
    end else passed++;
    total++;
    if ({alu_a, alu_b, alu_sel} !== 19'd0) begin
      $display("FAIL reset_alu: alu_a=%0h alu_b=%0h alu_sel=%0h, want 0", alu_a, alu_b, alu_sel);
    end else passed++;
    total++;
    if (op_count !== 4'd0) begin
      $display("FAIL reset_count: op_count=%0d, want 0", op_count);
    end else passed++;
    rst = 1'b0;
    model_last = 1'b1;
    exp_count  = 0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'd0) begin
      $display("FAIL idle_no_ready: req0_ready=%0d req1_ready=%0d busy=%0d, want 0",
               req0_ready, req1_ready, busy);
    end else passed++;
  endtask

  task automatic test_single();
    logic gid, both, rid, ok;
    int acc, lat;
    logic [7:0] d;
    logic [8:0] e;
    drive_op(1'b1, 1'b0, 8'd3, 8'd4, 8'd0, 8'd0, 1'b0, gid, both, acc, lat, d, rid, ok);
    total++;
    if (!ok || gid !== 1'b0 || lat != 2) begin
      $display("FAIL single_issue: done=%0d grant=%0d latency=%0d, want done=1 grant=0 latency=2",
               ok, gid, lat);
    end else passed++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    total++;
    if ({rid, d} !== e || d !== 8'd7) begin
      $display("FAIL single_rsp: id=%0d data=%0d, want id=%0d data=%0d", rid, d, e[8], e[7:0]);
    end else passed++;
    @(negedge clk);
    total++;
    if (op_count !== CNTW'(exp_count) || busy !== 1'b0) begin
      $display("FAIL single_count: op_count=%0d busy=%0d, want op_count=%0d busy=0",
               op_count, busy, exp_count);
    end else passed++;
  endtask

  task automatic test_alternate();
    logic gid, both, rid, ok;
    int acc, lat, prev;
    logic [7:0] d;
    logic [8:0] e;
    logic [1:0] k2;
    prev = 0;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      k2 = 2'(k);
      drive_op(1'b1, 1'b1, 8'd1, 8'd1, 8'd2, 8'd2, 1'b1, gid, both, acc, lat, d, rid, ok);
      total++;
      if (!ok || gid !== k2[0] || both !== 1'b0) begin
        $display("FAIL alt_grant[%0d]: done=%0d grant=%0d both_ready=%0d, want grant=%0d both_ready=0",
                 k, ok, gid, both, k2[0]);
      end else passed++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      total++;
      if ({rid, d} !== e || d !== (k2[0] ? 8'd4 : 8'd2)) begin
        $display("FAIL alt_rsp[%0d]: id=%0d data=%0d, want id=%0d data=%0d", k, rid, d, e[8], e[7:0]);
      end else passed++;
      if (k > 0) begin
        total++;
        if (acc - prev != 3) begin
          $display("FAIL alt_interval[%0d]: interval=%0d, want 3", k, acc - prev);
        end else passed++;
      end
      prev = acc;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (op_count !== CNTW'(exp_count)) begin
      $display("FAIL alt_count: op_count=%0d, want %0d", op_count, exp_count);
    end else passed++;
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    int n;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h02; req1_sel = 3'd2;
    rsp_ready  = 1'b0;
    #1;
    n = 0;
    while (!req1_ready && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      $display("FAIL bp_accept: req1_ready=%0d req0_ready=%0d, want 1 and 0", req1_ready, req0_ready);
    end else passed++;
    exp_q.push_back({1'b1, 8'h01});
    model_last = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy} !== {1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1}) begin
        $display("FAIL bp_hold[%0d]: rsp_valid=%0d rsp_id=%0d rsp_data=%0h readys=%0d%0d busy=%0d, want 1 1 01 00 1",
                 c, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy);
      end else passed++;
      @(negedge clk);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    total++;
    if ({rsp_id, rsp_data} !== e) begin
      $display("FAIL bp_rsp: id=%0d data=%0h, want id=%0d data=%0h", rsp_id, rsp_data, e[8], e[7:0]);
    end else passed++;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    exp_count  = exp_count + 1;
    @(negedge clk);
    total++;
    if (op_count !== CNTW'(exp_count) || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("FAIL bp_release: op_count=%0d busy=%0d rsp_valid=%0d, want %0d 0 0",
               op_count, busy, rsp_valid, exp_count);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    logic gid, both, rid, ok;
    int acc, lat;
    logic [7:0] d;
    logic [8:0] e;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd6; req0_sel = 3'd1;
    rsp_ready  = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin
      $display("FAIL mid_accept: req0_ready=%0d, want 1", req0_ready);
    end else passed++;
    @(negedge clk);
    req0_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || alu_a !== 8'd5 || alu_b !== 8'd6 || alu_sel !== 3'd1) begin
      $display("FAIL mid_exec: busy=%0d alu_a=%0d alu_b=%0d alu_sel=%0d, want 1 5 6 1",
               busy, alu_a, alu_b, alu_sel);
    end else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({rsp_valid, busy, alu_a, alu_b, alu_sel, op_count} !== {2'b00, 19'd0, 4'd0}) begin
      $display("FAIL mid_reset: rsp_valid=%0d busy=%0d alu=%0h/%0h/%0h op_count=%0d, want all 0",
               rsp_valid, busy, alu_a, alu_b, alu_sel, op_count);
    end else passed++;
    rst = 1'b0;
    model_last = 1'b1;
    exp_count  = 0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL mid_no_rsp[%0d]: rsp_valid=%0d busy=%0d, want 0 0", c, rsp_valid, busy);
      end else passed++;
    end
    drive_op(1'b1, 1'b1, 8'd5, 8'd6, 8'd7, 8'd7, 1'b0, gid, both, acc, lat, d, rid, ok);
    total++;
    if (!ok || gid !== 1'b0) begin
      $display("FAIL mid_first_grant: done=%0d grant=%0d, want grant=0", ok, gid);
    end else passed++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    total++;
    if ({rid, d} !== e) begin
      $display("FAIL mid_rsp: id=%0d data=%0d, want id=%0d data=%0d", rid, d, e[8], e[7:0]);
    end else passed++;
  endtask

  task automatic test_wrap();
    logic gid, both, rid, ok;
    int acc, lat;
    logic [7:0] d;
    logic [8:0] e;
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      drive_op(1'b1, 1'b0, 8'(k * 3), 8'(k + 100), 8'd0, 8'd0, 1'b0, gid, both, acc, lat, d, rid, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      total++;
      if (!ok || {rid, d} !== e) begin
        $display("FAIL wrap_rsp[%0d]: done=%0d id=%0d data=%0d, want id=%0d data=%0d",
                 k, ok, rid, d, e[8], e[7:0]);
      end else passed++;
      @(negedge clk);
      if (k >= 14) begin
        total++;
        if (op_count !== CNTW'(exp_count) || op_count !== ((k == 15) ? 4'h0 : 4'hF)) begin
          $display("FAIL wrap_count[%0d]: op_count=%0h, want %0h", k, op_count, CNTW'(exp_count));
        end else passed++;
      end
    end
  endtask

  task automatic test_req1_only();
    logic gid, both, rid, ok;
    int acc, lat;
    logic [7:0] d;
    logic [8:0] e;
    for (int k = 0; k < 3; k++) begin
      drive_op(1'b0, 1'b1, 8'd0, 8'd0, 8'(k + 10), 8'(k * 7), 1'b0, gid, both, acc, lat, d, rid, ok);
      total++;
      if (!ok || gid !== 1'b1) begin
        $display("FAIL r1_grant[%0d]: done=%0d grant=%0d, want 1", k, ok, gid);
      end else passed++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      total++;
      if ({rid, d} !== e) begin
        $display("FAIL r1_rsp[%0d]: id=%0d data=%0d, want id=%0d data=%0d", k, rid, d, e[8], e[7:0]);
      end else passed++;
    end
    repeat (3) @(negedge clk);
    drive_op(1'b1, 1'b1, 8'd20, 8'd30, 8'd40, 8'd50, 1'b0, gid, both, acc, lat, d, rid, ok);
    total++;
    if (!ok || gid !== 1'b0 || both !== 1'b0) begin
      $display("FAIL r1_then_both: done=%0d grant=%0d both_ready=%0d, want grant=0 both_ready=0",
               ok, gid, both);
    end else passed++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    total++;
    if ({rid, d} !== e || d !== 8'd50) begin
      $display("FAIL r1_both_rsp: id=%0d data=%0d, want id=%0d data=%0d", rid, d, e[8], e[7:0]);
    end else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    cyc    = 0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_req1_only();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
